// File: rtl/lht_pkg.sv
// lht_pkg: shared state encoding and pointer-width helper for the local history table
package lht_pkg;

    typedef enum logic {IDLE, RECOVER} lht_state_e;

    function automatic int ckpt_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/lht_ckpt_fifo.sv
// lht_ckpt_fifo: checkpoint circular buffer; push at tail, pop at head, walk read counted back from tail
module lht_ckpt_fifo
    import lht_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [ckpt_ptr_w(DEPTH)-1:0] walk_off,
    output entry_t                     walk_data,
    output logic                       full,
    output logic                       empty,
    output logic [ckpt_ptr_w(DEPTH):0] count
);
    localparam int PW = ckpt_ptr_w(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   tail;
    logic [PW-1:0]   walk_idx;

    // Head is implied by tail - count, so only tail and count are stored.
    assign walk_idx  = tail - walk_off - PW'(1);
    assign walk_data = mem[walk_idx];
    assign full      = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;

    // Tail pointer and occupancy; clear empties the buffer after a recovery walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Checkpoint storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_data;
    end

endmodule

// File: rtl/local_history_table_ckpt.sv
// local_history_table_ckpt: speculative per-branch local history with checkpoint unwind (LHT_PERF_CNT_EN adds a mispredict counter)
module local_history_table_ckpt
    import lht_pkg::*;
#(
    parameter int INDEX_LEN   = 7,
    parameter int HISTORY_LEN = 10,
    parameter int CKPT_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_LEN-1:0]   pc_bits_read,
    output logic [HISTORY_LEN-1:0] history_read,
    input  logic                   predict_valid,
    output logic                   predict_ready,
    input  logic [INDEX_LEN-1:0]   predict_index,
    input  logic                   prediction,
    input  logic                   resolve_valid,
    output logic                   resolve_ready,
    input  logic                   resolve_mispredict,
    input  logic                   resolve_taken,
    output logic                   recovering,
    output logic                   resolve_err,
    output logic [31:0]            mispredict_count
);
    localparam int LOCATIONS = 2**INDEX_LEN;
    localparam int PW        = ckpt_ptr_w(CKPT_DEPTH);

    typedef struct packed {
        logic [INDEX_LEN-1:0]   index;
        logic [HISTORY_LEN-1:0] old_hist;
    } ckpt_entry_t;

    lht_state_e             state, state_next;
    logic [PW-1:0]          walk, walk_next;
    logic                   taken_q;
    logic [HISTORY_LEN-1:0] hist [LOCATIONS];
    ckpt_entry_t            push_entry, walk_entry;
    logic                   full, empty, p_acc, pop, clear, mis_acc, is_head;
    logic [PW:0]            count;

    assign history_read = hist[pc_bits_read];
    assign push_entry   = '{index: predict_index, old_hist: hist[predict_index]};

    lht_ckpt_fifo #(.DEPTH(CKPT_DEPTH), .entry_t(ckpt_entry_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (p_acc),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (clear),
        .walk_off  (walk),
        .walk_data (walk_entry),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Handshakes and next state; a mispredict squashes any same-cycle predict.
    always_comb begin
        state_next    = state;
        walk_next     = walk;
        predict_ready = 1'b0;
        resolve_ready = 1'b0;
        recovering    = 1'b0;
        p_acc         = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        mis_acc       = 1'b0;
        is_head       = 1'b0;
        if (state == IDLE) begin
            predict_ready = !full;
            resolve_ready = 1'b1;
            mis_acc       = resolve_valid && resolve_mispredict && !empty;
            p_acc         = predict_valid && !full && !mis_acc;
            pop           = resolve_valid && !resolve_mispredict && !empty;
            state_next    = mis_acc ? RECOVER : IDLE;
            walk_next     = mis_acc ? '0 : walk;
        end else begin
            recovering = 1'b1;
            is_head    = {1'b0, walk} == count - (PW+1)'(1);
            walk_next  = walk + PW'(1);
            clear      = is_head;
            state_next = is_head ? IDLE : RECOVER;
        end
    end

    // FSM state, walk pointer, latched actual outcome and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            walk        <= '0;
            taken_q     <= 1'b0;
            resolve_err <= 1'b0;
        end else begin
            state <= state_next;
            walk  <= walk_next;
            if (mis_acc)
                taken_q <= resolve_taken;
            if (state == IDLE && resolve_valid && empty)
                resolve_err <= 1'b1;
        end
    end

    // History registers: speculative shift on predict, youngest-first restore on recovery.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LOCATIONS; i++)
                hist[i] <= '0;
        end else if (p_acc) begin
            hist[predict_index] <= {hist[predict_index][HISTORY_LEN-2:0], prediction};
        end else if (recovering) begin
            hist[walk_entry.index] <= is_head ? {walk_entry.old_hist[HISTORY_LEN-2:0], taken_q}
                                              : walk_entry.old_hist;
        end
    end

`ifdef LHT_PERF_CNT_EN
    logic [31:0] mis_cnt;

    // Saturating count of accepted mispredict resolves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mis_cnt <= '0;
        else if (mis_acc && mis_cnt != '1)
            mis_cnt <= mis_cnt + 32'd1;
    end

    assign mispredict_count = mis_cnt;
`else
    assign mispredict_count = '0;
`endif

endmodule
